sdram_read: RTL and testbench

//  Read master for the single-bank SDRAM controller; the counterpart of the write master.
//  rd_trig starts a read of RD_ROWS rows x COL_NUM columns from bank 0, starting at row 0, col 0.

---
 rtl/sdram_read_pkg.sv | 27 ++
 rtl/sdram_rd_capture.sv | 44 ++++
 rtl/sdram_read.sv | 196 +++++++++++++++++++
 tb/tb_sdram_read.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_read_pkg.sv
// rtl/sdram_read_pkg.sv - shared SDRAM command codes, timing defaults and read-master state type
package sdram_read_pkg;

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_READ = 4'b0101;
    localparam logic [3:0] CMD_PRE  = 4'b0010;

    // Must match the mode register programmed by the init master.
    localparam int CL_DEF = 3;
    localparam int BL_DEF = 4;

    // PRE with A10=1 closes every bank.
    localparam logic [12:0] PRE_ALL_ADDR = 13'h0400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACT,
        S_TRCD,
        S_RD,
        S_DRAIN,
        S_PRE
    } rd_state_t;

endpackage

// File: rtl/sdram_rd_capture.sv
// rtl/sdram_rd_capture.sv - read data capture: valid-tag pipeline plus DQ sampling register
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   rd_issue     high in the cycle a READ command is on the SDRAM bus
//   rd_dq        SDRAM data input
//   rd_data      captured word
//   rd_data_vld  rd_data holds a fresh word this cycle
module sdram_rd_capture #(
    parameter int CL = 3,
    parameter int BL = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_issue,
    input  logic [15:0] rd_dq,
    output logic [15:0] rd_data,
    output logic        rd_data_vld
);

    localparam int DEPTH = CL + BL - 1;

    // tag[i] is high in cycle t+1+i for a READ issued in cycle t.
    logic [DEPTH-1:0] tag;
    logic             sample;

    // Words of a burst arrive in cycles t+CL .. t+CL+BL-1.
    assign sample = |tag[DEPTH-1:CL-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag         <= '0;
            rd_data     <= '0;
            rd_data_vld <= 1'b0;
        end else begin
            tag         <= {tag[DEPTH-2:0], rd_issue};
            rd_data_vld <= sample;
            if (sample) begin
                rd_data <= rd_dq;
            end
        end
    end

endmodule

// File: rtl/sdram_read.sv
// rtl/sdram_read.sv - SDRAM read master: ACT/READ/PRE sequencing with refresh yield at burst boundaries
//
// Ports:
//   clk, rst_n   clock (SDRAM clock is ~clk), asynchronous active-low reset
//   rd_trig      start pulse, ignored while busy
//   aref_req     refresh pending; read yields at the next burst boundary
//   rd_en        arbiter grant pulse, honoured only while requesting
//   rd_req       request to the arbiter
//   flag_rd_end  one-cycle pulse: segment done, bank precharged
//   rd_cmd       {CS_N,RAS_N,CAS_N,WE_N}
//   rd_addr      SDRAM address bus
//   rd_dq        SDRAM data input
//   rd_data      captured word, valid with rd_data_vld
//   rd_busy      transfer in progress
module sdram_read
    import sdram_read_pkg::*;
#(
    parameter int CL      = CL_DEF,
    parameter int BL      = BL_DEF,
    parameter int TRCD    = 2,
    parameter int TRP     = 2,
    parameter int COL_NUM = 512,
    parameter int RD_ROWS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_trig,
    input  logic        aref_req,
    input  logic        rd_en,
    output logic        rd_req,
    output logic        flag_rd_end,
    output logic [3:0]  rd_cmd,
    output logic [12:0] rd_addr,
    input  logic [15:0] rd_dq,
    output logic [15:0] rd_data,
    output logic        rd_data_vld,
    output logic        rd_busy
);

    localparam logic [7:0]  TRCD_LAST = 8'(TRCD - 2);
    localparam logic [7:0]  BL_LAST   = 8'(BL - 1);
    localparam logic [7:0]  CL_LAST   = 8'(CL - 1);
    localparam logic [7:0]  TRP_LAST  = 8'(TRP - 1);
    localparam logic [8:0]  COL_STEP  = 9'(BL);
    localparam logic [8:0]  COL_LAST  = 9'(COL_NUM - BL);
    localparam logic [12:0] ROW_LAST  = 13'(RD_ROWS - 1);

    rd_state_t   state, next_state;
    logic [7:0]  cnt, cnt_next;
    logic [8:0]  col, col_next;
    logic [12:0] row, row_next;
    logic        row_done, row_done_next;
    logic [3:0]  cmd_next;
    logic [12:0] addr_next;
    logic        flag_next;
    logic        last_burst;

    assign last_burst = (col == COL_LAST);

    always_comb begin
        next_state    = state;
        cnt_next      = cnt;
        col_next      = col;
        row_next      = row;
        row_done_next = row_done;
        cmd_next      = CMD_NOP;
        addr_next     = rd_addr;
        flag_next     = 1'b0;

        case (state)
            S_IDLE: begin
                if (rd_trig) begin
                    next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (rd_en) begin
                    next_state = S_ACT;
                    cnt_next   = '0;
                end
            end
            S_ACT: begin
                cmd_next   = CMD_ACT;
                addr_next  = row;
                cnt_next   = '0;
                next_state = (TRCD == 1) ? S_RD : S_TRCD;
            end
            S_TRCD: begin
                if (cnt == TRCD_LAST) begin
                    cnt_next   = '0;
                    next_state = S_RD;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            S_RD: begin
                if (cnt == '0) begin
                    cmd_next  = CMD_READ;
                    addr_next = {4'b0000, col};
                end
                if (cnt == BL_LAST) begin
                    cnt_next = '0;
                    // End of row takes priority over a refresh yield so only one PRE is issued.
                    if (last_burst) begin
                        col_next      = '0;
                        row_done_next = 1'b1;
                        next_state    = S_DRAIN;
                    end else begin
                        col_next = col + COL_STEP;
                        if (aref_req) begin
                            next_state = S_DRAIN;
                        end
                    end
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            S_DRAIN: begin
                // Let the last burst's data come off the bus before closing the row.
                if (cnt == CL_LAST) begin
                    cnt_next   = '0;
                    next_state = S_PRE;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            S_PRE: begin
                if (cnt == '0) begin
                    cmd_next  = CMD_PRE;
                    addr_next = PRE_ALL_ADDR;
                end
                if (cnt == TRP_LAST) begin
                    flag_next = 1'b1;
                    cnt_next  = '0;
                    if (!row_done) begin
                        // Refresh yield: col already points at the next burst.
                        next_state = S_REQ;
                    end else if (row == ROW_LAST) begin
                        next_state    = S_IDLE;
                        row_next      = '0;
                        col_next      = '0;
                        row_done_next = 1'b0;
                    end else begin
                        next_state    = S_REQ;
                        row_next      = row + 13'd1;
                        row_done_next = 1'b0;
                    end
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            col         <= '0;
            row         <= '0;
            row_done    <= 1'b0;
            rd_cmd      <= CMD_NOP;
            rd_addr     <= '0;
            flag_rd_end <= 1'b0;
            rd_req      <= 1'b0;
            rd_busy     <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_next;
            col         <= col_next;
            row         <= row_next;
            row_done    <= row_done_next;
            rd_cmd      <= cmd_next;
            rd_addr     <= addr_next;
            flag_rd_end <= flag_next;
            rd_req      <= (next_state == S_REQ);
            rd_busy     <= (next_state != S_IDLE);
        end
    end

    sdram_rd_capture #(
        .CL (CL),
        .BL (BL)
    ) u_capture (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_issue    (rd_cmd == CMD_READ),
        .rd_dq       (rd_dq),
        .rd_data     (rd_data),
        .rd_data_vld (rd_data_vld)
    );

endmodule

// File: tb/tb_sdram_read.sv
// tb/tb_sdram_read.sv - directed self-checking bench for sdram_read
module tb_sdram_read;
    import sdram_read_pkg::*;

    localparam int BL     = 4;
    localparam int CL_A   = 3;
    localparam int TRCD_A = 2;
    localparam int TRP_A  = 2;
    localparam int CL_B   = 2;
    localparam int TRCD_B = 3;
    localparam int TRP_B  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trig_a = 1'b0, trig_b = 1'b0;
    logic        aref_a = 1'b0, aref_b = 1'b0;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic [15:0] rd_dq = 16'h0;

    logic        req_a, flag_a, vld_a, busy_a;
    logic        req_b, flag_b, vld_b, busy_b;
    logic [3:0]  cmd_a, cmd_b;
    logic [12:0] addr_a, addr_b;
    logic [15:0] data_a, data_b;

    sdram_read #(.CL(CL_A), .BL(BL), .TRCD(TRCD_A), .TRP(TRP_A), .COL_NUM(8), .RD_ROWS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_trig(trig_a), .aref_req(aref_a), .rd_en(en_a),
        .rd_req(req_a), .flag_rd_end(flag_a), .rd_cmd(cmd_a), .rd_addr(addr_a),
        .rd_dq(rd_dq), .rd_data(data_a), .rd_data_vld(vld_a), .rd_busy(busy_a)
    );

    sdram_read #(.CL(CL_B), .BL(BL), .TRCD(TRCD_B), .TRP(TRP_B), .COL_NUM(16), .RD_ROWS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_trig(trig_b), .aref_req(aref_b), .rd_en(en_b),
        .rd_req(req_b), .flag_rd_end(flag_b), .rd_cmd(cmd_b), .rd_addr(addr_b),
        .rd_dq(rd_dq), .rd_data(data_b), .rd_data_vld(vld_b), .rd_busy(busy_b)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          act_cyc[$], act_row[$], rd_cyc[$], rd_col[$], pre_cyc[$], flag_cyc[$], vld_cyc[$];
    logic [15:0] vld_dat[$];
    logic [15:0] sched[64];
    logic [12:0] arow_a = '0, arow_b = '0;
    int          g_a = 0, g_b = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Event log, SDRAM data model ({row,col} words after CL) and arbiter granting 2 cycles after rd_req.
    initial forever begin
        @(negedge clk);
        if (cmd_a == CMD_ACT) begin act_cyc.push_back(cyc); act_row.push_back(int'(addr_a)); arow_a = addr_a; end
        if (cmd_b == CMD_ACT) begin act_cyc.push_back(cyc); act_row.push_back(int'(addr_b)); arow_b = addr_b; end
        if (cmd_a == CMD_READ) begin
            rd_cyc.push_back(cyc); rd_col.push_back(int'(addr_a[8:0]));
            for (int k = 0; k < BL; k++) sched[(cyc + CL_A + k) % 64] = {arow_a[7:0], addr_a[7:0] + 8'(k)};
        end
        if (cmd_b == CMD_READ) begin
            rd_cyc.push_back(cyc); rd_col.push_back(int'(addr_b[8:0]));
            for (int k = 0; k < BL; k++) sched[(cyc + CL_B + k) % 64] = {arow_b[7:0], addr_b[7:0] + 8'(k)};
        end
        if (cmd_a == CMD_PRE || cmd_b == CMD_PRE) pre_cyc.push_back(cyc);
        if (flag_a || flag_b) flag_cyc.push_back(cyc);
        if (vld_a) begin vld_cyc.push_back(cyc); vld_dat.push_back(data_a); end
        if (vld_b) begin vld_cyc.push_back(cyc); vld_dat.push_back(data_b); end
        if (req_a) begin g_a = g_a + 1; en_a = (g_a == 3); end else begin g_a = 0; en_a = 1'b0; end
        if (req_b) begin g_b = g_b + 1; en_b = (g_b == 3); end else begin g_b = 0; en_b = 1'b0; end
        rd_dq = sched[cyc % 64];
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        act_cyc.delete(); act_row.delete(); rd_cyc.delete(); rd_col.delete();
        pre_cyc.delete(); flag_cyc.delete(); vld_cyc.delete(); vld_dat.delete();
    endtask

    task automatic wait_flags(input string tag, input int n, input int budget);
        int i = 0;
        while (flag_cyc.size() < n && i < budget) begin @(posedge clk); i++; end
        check(tag, flag_cyc.size() >= n, 1);
    endtask

    task automatic wait_reads(input string tag, input int n, input int budget);
        int i = 0;
        while (rd_cyc.size() < n && i < budget) begin @(posedge clk); i++; end
        check(tag, rd_cyc.size() >= n, 1);
    endtask

    task automatic pulse_a();
        @(negedge clk); trig_a = 1'b1;
        @(negedge clk); trig_a = 1'b0;
    endtask

    function automatic longint q_int(input int q[$], input int i);
        return (i < q.size()) ? longint'(q[i]) : -1;
    endfunction

    function automatic longint q_dat(input int i);
        return (i < vld_dat.size()) ? longint'(vld_dat[i]) : -1;
    endfunction

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd", cmd_a, CMD_NOP);
        check("rst_addr", addr_a, 0);
        check("rst_data", data_a, 0);
        check("rst_vld", vld_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_req", req_a, 0);
        check("rst_flag", flag_a, 0);
        check("rst_cmd_b", cmd_b, CMD_NOP);
        @(negedge clk); rst_n = 1'b1;

        // Two rows of 8 columns, no refresh
        clear_logs();
        pulse_a();
        check("t1_busy_set", busy_a, 1);
        wait_flags("t1_timeout", 2, 300);
        @(negedge clk);
        check("t1_busy_clr", busy_a, 0);
        check("t1_acts", act_cyc.size(), 2);
        check("t1_row0", q_int(act_row, 0), 0);
        check("t1_row1", q_int(act_row, 1), 1);
        check("t1_reads", rd_cyc.size(), 4);
        for (int i = 0; i < 4; i++) check("t1_col", q_int(rd_col, i), (i % 2) * 4);
        check("t1_rd_space", q_int(rd_cyc, 1) - q_int(rd_cyc, 0), BL);
        check("t1_trcd", q_int(rd_cyc, 0) - q_int(act_cyc, 0), TRCD_A);
        check("t1_pres", pre_cyc.size(), 2);
        check("t1_pre_pos", q_int(pre_cyc, 0) - q_int(rd_cyc, 1), BL + CL_A);
        check("t1_flag_pos", q_int(flag_cyc, 0) - q_int(pre_cyc, 0), TRP_A - 1);
        check("t1_flags", flag_cyc.size(), 2);
        check("t1_vld_cnt", vld_dat.size(), 16);
        check("t2_first_vld", q_int(vld_cyc, 0) - q_int(rd_cyc, 0), CL_A + 1);
        check("t2_gapless", q_int(vld_cyc, 7) - q_int(vld_cyc, 0), 7);
        for (int i = 0; i < 16; i++) check("t2_data", q_dat(i), (i < 8) ? i : 256 + i - 8);

        // Re-trigger while busy has no effect
        clear_logs();
        pulse_a();
        wait_reads("t4_rd_timeout", 1, 100);
        pulse_a();
        wait_flags("t4_f1_timeout", 1, 200);
        pulse_a();
        wait_flags("t4_f2_timeout", 2, 200);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("t4_acts", act_cyc.size(), 2);
        check("t4_reads", rd_cyc.size(), 4);
        for (int i = 0; i < 4; i++) check("t4_col", q_int(rd_col, i), (i % 2) * 4);
        check("t4_vld_cnt", vld_dat.size(), 16);
        check("t4_flags", flag_cyc.size(), 2);
        check("t4_busy", busy_a, 0);

        // Reset in the middle of S_RD
        clear_logs();
        pulse_a();
        wait_reads("t5_rd_timeout", 2, 100);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_cmd", cmd_a, CMD_NOP);
        check("t5_addr", addr_a, 0);
        check("t5_vld", vld_a, 0);
        check("t5_data", data_a, 0);
        check("t5_busy", busy_a, 0);
        check("t5_req", req_a, 0);
        clear_logs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check("t5_no_vld", vld_dat.size(), 0);
        check("t5_no_rd", rd_cyc.size(), 0);
        pulse_a();
        wait_flags("t5_timeout", 2, 300);
        check("t5_row", q_int(act_row, 0), 0);
        check("t5_col", q_int(rd_col, 0), 0);
        check("t5_vld_cnt", vld_dat.size(), 16);
        check("t5_first", q_dat(0), 0);

        // Refresh yield on a 16-column row with TRCD=3, TRP=3, CL=2
        clear_logs();
        @(negedge clk); trig_b = 1'b1;
        @(negedge clk); trig_b = 1'b0;
        wait_reads("t3_rd_timeout", 2, 100);
        @(negedge clk); aref_b = 1'b1;
        wait_flags("t3_yield_timeout", 1, 100);
        @(negedge clk); aref_b = 1'b0;
        check("t3_req_after_flag", req_b, 1);
        check("t3_reads_before_yield", rd_cyc.size(), 2);
        wait_flags("t3_timeout", 3, 400);
        @(negedge clk);
        check("t3_acts", act_cyc.size(), 3);
        check("t3_act_row_a", q_int(act_row, 1), 0);
        check("t3_act_row_b", q_int(act_row, 2), 1);
        check("t3_reads", rd_cyc.size(), 8);
        for (int i = 0; i < 8; i++) check("t3_col", q_int(rd_col, i), (i % 4) * 4);
        check("t3_resume_trcd", q_int(rd_cyc, 2) - q_int(act_cyc, 1), TRCD_B);
        check("t3_yield_pre", q_int(pre_cyc, 0) - q_int(rd_cyc, 1), BL + CL_B);
        check("t3_pres", pre_cyc.size(), 3);
        check("t3_vld_cnt", vld_dat.size(), 32);
        for (int i = 0; i < 32; i++) check("t3_data", q_dat(i), (i < 16) ? i : 256 + i - 16);
        check("t3_busy", busy_b, 0);
        check("t6_trcd", q_int(rd_cyc, 0) - q_int(act_cyc, 0), TRCD_B);
        check("t6_trp", q_int(flag_cyc, 0) - q_int(pre_cyc, 0), TRP_B - 1);
        check("t6_cl", q_int(vld_cyc, 0) - q_int(rd_cyc, 0), CL_B + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
